// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with start-glitch rejection and line-break hold-off.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_8n1 #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t           state, state_nx;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [7:0]       data_nx;
    logic             valid_nx, ferr_nx, perr_nx;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_bit_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            data       <= data_nx;
            valid      <= valid_nx;
            frame_err  <= ferr_nx;
            parity_err <= perr_nx;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        data_nx    = data;
        valid_nx   = 1'b0;
        ferr_nx    = 1'b0;
        perr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nx = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx   = START;
                    clk_cnt_nx = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    state_nx   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_nx = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nx = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end else begin
                    clk_cnt_nx = clk_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nx = '0;
                    par_bit_nx = rx_s;
                    state_nx   = STOP;
                end else begin
                    clk_cnt_nx = clk_cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
                        // Framing is checked first; parity only matters on a good stop bit.
                        if (^{shreg, par_bit}) begin
                            perr_nx = 1'b1;
                        end else begin
                            data_nx  = shreg;
                            valid_nx = 1'b1;
                        end
`else
                        data_nx  = shreg;
                        valid_nx = 1'b1;
`endif
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
